// File: rtl/sign_extender_if.sv
// Immediate-extension bus. It groups the decode-side request with the registered operand returned to the datapath.
interface sign_extender_if;
    logic [15:0] data_in;
    logic [1:0]  ext_mode;
    logic        in_valid;
    logic [31:0] data_out;
    logic        out_valid;

    // Decode stage: drives the immediate and the extension form.
    modport master (
        output data_in,
        output ext_mode,
        output in_valid,
        input  data_out,
        input  out_valid
    );

    // Extension unit: consumes the immediate and returns the operand.
    modport slave (
        input  data_in,
        input  ext_mode,
        input  in_valid,
        output data_out,
        output out_valid
    );
endinterface

// File: rtl/sign_extender.sv
// MIPS immediate-field extension unit. It turns a 16-bit I-type immediate into a
// registered 32-bit operand in sign, zero, upper (LUI) or branch-offset form.
module sign_extender (
    input  logic            clk,
    input  logic            rst,
    sign_extender_if.slave  bus
);

    localparam logic [1:0] MODE_SIGN   = 2'b00;
    localparam logic [1:0] MODE_ZERO   = 2'b01;
    localparam logic [1:0] MODE_UPPER  = 2'b10;
    localparam logic [1:0] MODE_BRANCH = 2'b11;

    // Pure bit-rearrangement with no carry. The branch form is the sign-extended
    // value shifted left by two, so it is a word offset.
    function automatic logic [31:0] extend_imm(input logic [15:0] imm,
                                               input logic [1:0]  mode);
        logic [31:0] res;
        case (mode)
            MODE_SIGN:   res = {{16{imm[15]}}, imm};
            MODE_ZERO:   res = {16'h0000, imm};
            MODE_UPPER:  res = {imm, 16'h0000};
            MODE_BRANCH: res = {{14{imm[15]}}, imm, 2'b00};
            default:     res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    logic [31:0] data_out_d, data_out_q;
    logic        out_valid_d, out_valid_q;

    // Next state: load a new operand on a valid input, otherwise hold it so that idle inputs cannot disturb it.
    always_comb begin
        data_out_d  = data_out_q;
        out_valid_d = 1'b0;
        if (bus.in_valid == 1'b1) begin
            data_out_d  = extend_imm(bus.data_in, bus.ext_mode);
            out_valid_d = 1'b1;
        end else begin
            data_out_d  = data_out_q;
            out_valid_d = 1'b0;
        end
    end

    // Output registers. Reset clears them immediately and discards any in-flight result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_q  <= 32'h0000_0000;
            out_valid_q <= 1'b0;
        end else begin
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_sign_extender.sv
// Directed self-checking bench for sign_extender.
module tb_sign_extender;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    sign_extender_if bus ();

    sign_extender dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running clock with a 10-time-unit period. The first rising edge is at t=5.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive one input vector just after a falling edge, then sample 1 unit after the next rising edge.
    task automatic apply(input logic [15:0] d, input logic [1:0] m, input logic v);
        @(negedge clk);
        bus.data_in  = d;
        bus.ext_mode = m;
        bus.in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] d, input logic v);
        chk32({tag, "_data"}, bus.data_out, d);
        chk1({tag, "_valid"}, bus.out_valid, v);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b0;
        bus.data_in  = 16'h0000;
        bus.ext_mode = 2'b00;
        bus.in_valid = 1'b0;

        // Assert reset asynchronously, before the first clock edge.
        #2;
        rst = 1'b1;
        #1;
        expect_out("rst_async", 32'h0000_0000, 1'b0);
        @(posedge clk);
        #1;
        expect_out("rst_held", 32'h0000_0000, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        apply(16'h0000, 2'b00, 1'b0);
        expect_out("idle_after_rst", 32'h0000_0000, 1'b0);

        // Sign mode.
        apply(16'h000A, 2'b00, 1'b1); expect_out("sign_pos_a",   32'h0000_000A, 1'b1);
        apply(16'h0FFF, 2'b00, 1'b1); expect_out("sign_pos_fff", 32'h0000_0FFF, 1'b1);
        apply(16'hFFFF, 2'b00, 1'b1); expect_out("sign_neg_1",   32'hFFFF_FFFF, 1'b1);
        apply(16'h8000, 2'b00, 1'b1); expect_out("sign_neg_min", 32'hFFFF_8000, 1'b1);

        // Zero and upper modes.
        apply(16'hFFFF, 2'b01, 1'b1); expect_out("zero_ffff",  32'h0000_FFFF, 1'b1);
        apply(16'h8001, 2'b01, 1'b1); expect_out("zero_8001",  32'h0000_8001, 1'b1);
        apply(16'h1234, 2'b10, 1'b1); expect_out("upper_1234", 32'h1234_0000, 1'b1);
        apply(16'hFFFF, 2'b10, 1'b1); expect_out("upper_ffff", 32'hFFFF_0000, 1'b1);

        // Branch mode.
        apply(16'hFFFF, 2'b11, 1'b1); expect_out("br_neg1",  32'hFFFF_FFFC, 1'b1);
        apply(16'h7FFF, 2'b11, 1'b1); expect_out("br_7fff",  32'h0001_FFFC, 1'b1);
        apply(16'h8000, 2'b11, 1'b1); expect_out("br_8000",  32'hFFFE_0000, 1'b1);
        apply(16'h0001, 2'b11, 1'b1); expect_out("br_0001",  32'h0000_0004, 1'b1);

        // Valid gap: hold the previous value even when data_in and ext_mode are X.
        apply(16'h000A, 2'b00, 1'b1); expect_out("gap_load",  32'h0000_000A, 1'b1);
        apply(16'hBEEF, 2'b10, 1'b0); expect_out("gap_hold1", 32'h0000_000A, 1'b0);
        apply(16'hxxxx, 2'bxx, 1'b0); expect_out("gap_holdx", 32'h0000_000A, 1'b0);
        apply(16'h1234, 2'b00, 1'b1); expect_out("gap_resume", 32'h0000_1234, 1'b1);

        // Mid-stream reset: a pulse between edges clears at once, and an input seen under reset is dropped.
        @(negedge clk);
        bus.data_in  = 16'h5555;
        bus.ext_mode = 2'b01;
        bus.in_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        expect_out("mid_rst_async", 32'h0000_0000, 1'b0);
        @(posedge clk);
        #1;
        expect_out("mid_rst_edge", 32'h0000_0000, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        expect_out("post_rst_first", 32'h0000_5555, 1'b1);
        apply(16'h0000, 2'b00, 1'b0); expect_out("post_rst_idle", 32'h0000_5555, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sign_extender.md
# sign_extender

Immediate-field extension unit for the MIPS datapath, sitting between instruction decode and the ALU B-operand / branch-target adder. It takes the 16-bit immediate of an I-type instruction and produces a registered 32-bit operand. Supported forms: sign-extended, zero-extended, upper-immediate (LUI) and word-aligned branch offset.

## Interface
- No parameters; widths fixed at 16 in / 32 out.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  16  immediate field, instruction bits [15:0].
- ext_mode  input  2  extension form: 00 sign, 01 zero, 10 upper (LUI), 11 branch (sign-extend then ×4).
- in_valid  input  1  data_in/ext_mode qualify this cycle.
- data_out  output  32  extended immediate, registered.
- out_valid  output  1  data_out holds a result produced from a valid input.

## Operation
- Combinational result per ext_mode:
  - 00: {16{data_in[15]}, data_in}.
  - 01: {16'h0000, data_in}.
  - 10: {data_in, 16'h0000}.
  - 11: {14{data_in[15]}, data_in, 2'b00}. Bit 17 and above equal data_in[15]. Bits [1:0] are 0.
- Every bit of data_out is a pure function of data_in and ext_mode. No arithmetic carry. No saturation or overflow flag.
- When in_valid=1 at a rising edge: data_out <= result, out_valid <= 1.
- When in_valid=0 at a rising edge: data_out holds its previous value, out_valid <= 0.
- ext_mode is sampled only with in_valid. Its value is ignored when in_valid=0.
- X on data_in while in_valid=0 must not propagate to data_out.

## Timing
- Latency: one clock. A result is visible on data_out after the edge that samples in_valid=1.
- Throughput: one result per cycle. Back-to-back valid inputs produce back-to-back out_valid.
- No backpressure. The consumer must take data_out in the cycle where out_valid=1.
- Reset:
  - rst=1 forces data_out=32'h0000_0000 and out_valid=0 immediately, with no clock required.
  - Values remain forced while rst is held.
  - The first edge after rst deasserts samples normally.
- Reset mid-stream: any in-flight result is discarded. No output pulse is generated for an input sampled in the same edge in which rst is high.
- data_out is glitch-free between edges, since it is driven only by flops.

## Test plan
- Reset: assert rst with in_valid=0 -> data_out=0, out_valid=0 asynchronously, before any clock edge; release, then idle -> outputs unchanged.
- Sign mode positive: data_in=16'h000A, mode 00, valid -> next edge data_out=32'h0000_000A, out_valid=1. Then data_in=16'h0FFF -> 32'h0000_0FFF.
- Sign mode negative: data_in=16'hFFFF, mode 00 -> 32'hFFFF_FFFF. data_in=16'h8000 -> 32'hFFFF_8000.
- Zero and upper modes: data_in=16'hFFFF, mode 01 -> 32'h0000_FFFF. data_in=16'h1234, mode 10 -> 32'h1234_0000.
- Branch mode: data_in=16'hFFFF, mode 11 -> 32'hFFFF_FFFC. data_in=16'h7FFF -> 32'h0001_FFFC.
- Hold/valid gap and mid-stream reset:
  - After a valid 16'h000A, drop in_valid while data_in changes -> data_out stays 32'h0000_000A, out_valid=0.
  - Pulse rst between edges -> data_out=0 immediately.
